dcache_direct_wt: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the pipeline MEM stage and the data side of the cache-to-RAM arbiter.
- Serves read hits in the same cycle. Read misses and all writes go to RAM through the arbiter's data port (readDat/write/addressDat/value, ready = cacheDataReady).
- Stalls the pipeline while a RAM transaction is outstanding.

---
 rtl/dcache_direct_wt.sv | 127 ++++++++++++
 tb/tb_dcache_direct_wt.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dcache_direct_wt.sv
// dcache_direct_wt: direct-mapped, write-through, no-write-allocate data cache
module dcache_direct_wt #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpuRead,
  input  logic        cpuWrite,
  input  logic [31:0] cpuAddr,
  input  logic [31:0] cpuWData,
  output logic [31:0] cpuRData,
  output logic        stall,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  input  logic [31:0] memRData,
  input  logic        memReady,
  output logic [31:0] hitCount,
  output logic [31:0] missCount
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MISS  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]                     state_q, state_d;
  logic [29:0]                    addr_q, addr_d;
  logic [31:0]                    wdata_q, wdata_d;
  logic [31:0]                    rdata_q, rdata_d;
  logic [31:0]                    hit_cnt_q, hit_cnt_d;
  logic [31:0]                    miss_cnt_q, miss_cnt_d;
  logic [LINES-1:0]               valid_q, valid_d;
  logic [LINES-1:0][TAG_BITS-1:0] tag_q, tag_d;
  logic [LINES-1:0][31:0]         data_q, data_d;

  logic [INDEX_BITS-1:0] cpu_idx, fill_idx;
  logic [TAG_BITS-1:0]   cpu_tag, fill_tag;
  logic                  idle, hit, rd_hit;
  logic                  unused_ok;

  assign cpu_idx   = cpuAddr[INDEX_BITS+1:2];
  assign cpu_tag   = cpuAddr[31:INDEX_BITS+2];
  assign fill_idx  = addr_q[INDEX_BITS-1:0];
  assign fill_tag  = addr_q[29:INDEX_BITS];
  assign unused_ok = ^cpuAddr[1:0];
  assign idle      = state_q == IDLE;
  assign hit       = valid_q[cpu_idx] && tag_q[cpu_idx] == cpu_tag;
  assign rd_hit    = idle && cpuRead && !cpuWrite && hit;

  // Stall is gated by reset so the pipeline is released the instant reset is asserted
  assign stall     = reset && ((idle && (cpuWrite || (cpuRead && !hit))) || state_q == MISS || state_q == WRITE);
  assign cpuRData  = rd_hit ? data_q[cpu_idx] : rdata_q;
  assign memRead   = state_q == MISS;
  assign memWrite  = state_q == WRITE;
  assign memAddr   = {addr_q, 2'b00};
  assign memWData  = wdata_q;
  assign hitCount  = hit_cnt_q;
  assign missCount = miss_cnt_q;

  // Next-state: request decode in IDLE, line fill on read completion, write-through handshake
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    if (idle) begin
      if (cpuWrite) begin
        addr_d  = cpuAddr[31:2];
        wdata_d = cpuWData;
        state_d = WRITE;
        if (hit) data_d[cpu_idx] = cpuWData;
      end else if (cpuRead && hit) begin
        hit_cnt_d = hit_cnt_q + 32'd1;
        rdata_d   = data_q[cpu_idx];
      end else if (cpuRead) begin
        addr_d     = cpuAddr[31:2];
        miss_cnt_d = miss_cnt_q + 32'd1;
        state_d    = MISS;
      end
    end else if (state_q == MISS) begin
      if (memReady) begin
        data_d[fill_idx]  = memRData;
        valid_d[fill_idx] = 1'b1;
        tag_d[fill_idx]   = fill_tag;
        rdata_d           = memRData;
        state_d           = DONE;
      end
    end else if (state_q == WRITE) begin
      state_d = memReady ? DONE : WRITE;
    end else begin
      state_d = IDLE;
    end
  end

  // State and line storage; reset aborts any transaction and invalidates all lines
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '0;
      tag_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
    end
  end
endmodule

// File: tb/tb_dcache_direct_wt.sv
// tb_dcache_direct_wt: directed self-checking bench for dcache_direct_wt
module tb_dcache_direct_wt;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpuRead = 1'b0, cpuWrite = 1'b0;
  logic [31:0] cpuAddr = '0, cpuWData = '0, cpuRData;
  logic        stall, memRead, memWrite, memReady = 1'b0;
  logic [31:0] memAddr, memWData, memRData = '0, hitCount, missCount;
  int tests = 0, failed = 0;
  int stall_cycles;

  dcache_direct_wt dut (
    .clock(clock), .reset(reset), .cpuRead(cpuRead), .cpuWrite(cpuWrite),
    .cpuAddr(cpuAddr), .cpuWData(cpuWData), .cpuRData(cpuRData), .stall(stall),
    .memRead(memRead), .memWrite(memWrite), .memAddr(memAddr), .memWData(memWData),
    .memRData(memRData), .memReady(memReady), .hitCount(hitCount), .missCount(missCount)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic read_miss(input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_miss);
    cpuRead = 1'b1; cpuAddr = a;
    #1 chk("rm_req_stall", 32'(stall), 32'd1);
    chk("rm_req_nomemrd", 32'(memRead), 32'd0);
    tick();
    memReady = 1'b1; memRData = d;
    #1 chk("rm_memread", 32'(memRead), 32'd1);
    chk("rm_memaddr", memAddr, a);
    chk("rm_stall", 32'(stall), 32'd1);
    chk("rm_misscnt", missCount, exp_miss);
    tick();
    memReady = 1'b0;
    #1 chk("rm_done_stall", 32'(stall), 32'd0);
    chk("rm_done_data", cpuRData, d);
    chk("rm_done_nomemrd", 32'(memRead), 32'd0);
    cpuRead = 1'b0;
    tick();
  endtask

  task automatic read_hit(input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_hit);
    cpuRead = 1'b1; cpuAddr = a;
    #1 chk("rh_stall", 32'(stall), 32'd0);
    chk("rh_data", cpuRData, d);
    chk("rh_nomemrd", 32'(memRead), 32'd0);
    tick();
    chk("rh_hitcnt", hitCount, exp_hit);
    cpuRead = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_memread", 32'(memRead), 32'd0);
    chk("rst_memwrite", 32'(memWrite), 32'd0);
    chk("rst_rdata", cpuRData, 32'd0);
    chk("rst_hit", hitCount, 32'd0);
    chk("rst_miss", missCount, 32'd0);
    #21 reset = 1'b1;
    tick();
    // fill 0x40, then same-cycle hit
    read_miss(32'h40, 32'hDEADBEEF, 32'd1);
    read_hit(32'h40, 32'hDEADBEEF, 32'd1);
    // write hit to 0x40 with two wait cycles
    cpuWrite = 1'b1; cpuAddr = 32'h40; cpuWData = 32'h12345678;
    #1 chk("wr_req_stall", 32'(stall), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      memReady = (i == 2);
      #1 chk("wr_memwrite", 32'(memWrite), 32'd1);
      chk("wr_memread", 32'(memRead), 32'd0);
      chk("wr_memaddr", memAddr, 32'h40);
      chk("wr_wdata", memWData, 32'h12345678);
      chk("wr_stall", 32'(stall), 32'd1);
      tick();
    end
    memReady = 1'b0; cpuWrite = 1'b0;
    chk("wr_done_stall", 32'(stall), 32'd0);
    chk("wr_done_memwrite", 32'(memWrite), 32'd0);
    tick();
    read_hit(32'h40, 32'h12345678, 32'd2);
    // read miss 0x80 with memReady low for 5 cycles
    cpuRead = 1'b1; cpuAddr = 32'h80; memRData = 32'hCAFEF00D;
    #1 chk("slow_req_stall", 32'(stall), 32'd1);
    tick();
    stall_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      memReady = (i == 5);
      #1 chk("slow_memread", 32'(memRead), 32'd1);
      chk("slow_memaddr", memAddr, 32'h80);
      if (stall) stall_cycles++;
      tick();
    end
    chk("slow_stall_cycles", 32'(stall_cycles), 32'd6);
    memReady = 1'b0;
    chk("slow_done_stall", 32'(stall), 32'd0);
    chk("slow_done_data", cpuRData, 32'hCAFEF00D);
    chk("slow_misscnt", missCount, 32'd2);
    cpuRead = 1'b0;
    tick();
    // write miss to 0x100: no allocation
    cpuWrite = 1'b1; cpuAddr = 32'h100; cpuWData = 32'h55AA55AA;
    #1 chk("wm_req_stall", 32'(stall), 32'd1);
    tick();
    memReady = 1'b1;
    #1 chk("wm_memwrite", 32'(memWrite), 32'd1);
    chk("wm_memaddr", memAddr, 32'h100);
    chk("wm_wdata", memWData, 32'h55AA55AA);
    tick();
    memReady = 1'b0; cpuWrite = 1'b0;
    tick();
    read_miss(32'h100, 32'h0BADF00D, 32'd3);
    // aliasing on index 0
    read_miss(32'h40, 32'h11111111, 32'd4);
    read_miss(32'h80, 32'h22222222, 32'd5);
    read_miss(32'h40, 32'h33333333, 32'd6);
    read_hit(32'h40, 32'h33333333, 32'd3);
    // reset in the middle of a miss
    cpuRead = 1'b1; cpuAddr = 32'h80;
    tick();
    #1 chk("mid_memread", 32'(memRead), 32'd1);
    #2 reset = 1'b0;
    #1 chk("mid_rst_memread", 32'(memRead), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_hit", hitCount, 32'd0);
    chk("mid_rst_miss", missCount, 32'd0);
    cpuRead = 1'b0;
    #1 reset = 1'b1;
    tick();
    read_miss(32'h40, 32'h44444444, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
